// File: rtl/beat_timer_pkg.sv
// +-----------------------------------------------------------------+
// | beat_timer_pkg : shared state encoding and defaults             |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
`default_nettype none

package beat_timer_pkg;

  localparam int DEF_WIDTH   = 6;
  localparam int DEF_PRESC_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/beat_prescaler.sv
// +-----------------------------------------------------------------+
// | beat_prescaler : emits every (div_i+1)-th tick, clear and hold   |
// | Present only when BEAT_TIMER_PRESCALE_EN is defined. Rev 1.0    |
// +-----------------------------------------------------------------+
`default_nettype none

`ifdef BEAT_TIMER_PRESCALE_EN
module beat_prescaler
  import beat_timer_pkg::*;
#(
  parameter int PRESC_W = DEF_PRESC_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick_i,
  input  logic [PRESC_W-1:0] div_i,
  input  logic               clr_i,
  input  logic               hold_i,
  output logic               tick_o
);

  logic [PRESC_W-1:0] cnt_q;
  logic [PRESC_W-1:0] cnt_d;
  logic               wrap;

  // >= keeps the divider sane if div_i is lowered below the current count
  assign wrap   = tick_i && !hold_i && (cnt_q >= div_i);
  assign tick_o = wrap;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (tick_i && !hold_i) begin
      cnt_d = wrap ? '0 : cnt_q + PRESC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`endif

`default_nettype wire

// File: rtl/beat_timer_gen.sv
// +-----------------------------------------------------------------+
// | beat_timer_gen : per-note beat countdown with pause/abort/reload |
// | Optional tick prescaler: BEAT_TIMER_PRESCALE_EN. Rev 1.0         |
// +-----------------------------------------------------------------+
`default_nettype none

module beat_timer_gen
  import beat_timer_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter bit RELOAD_DEFAULT = 1'b0
`ifdef BEAT_TIMER_PRESCALE_EN
  , parameter int PRESC_W      = DEF_PRESC_W
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick_en,
`ifdef BEAT_TIMER_PRESCALE_EN
  input  logic [PRESC_W-1:0] presc_div,
`endif
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [WIDTH-1:0]   duration,
  input  logic               auto_reload,
  input  logic               pause,
  input  logic               abort,
  output logic               busy,
  output logic               paused,
  output logic [WIDTH-1:0]   remaining,
  output logic               timer_done
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   dur_q, dur_d;
  logic               reload_q, reload_d;
  logic               done_q, done_d;
  logic               eff_tick;
  logic               term;
  logic               accept;

`ifdef BEAT_TIMER_PRESCALE_EN
  logic presc_clr;
  logic presc_hold;

  // Terminal tick always restarts the division, whether reloading or not
  assign presc_clr  = abort || accept || term;
  assign presc_hold = pause || (state_q != ST_RUN);

  beat_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick_i (tick_en),
    .div_i  (presc_div),
    .clr_i  (presc_clr),
    .hold_i (presc_hold),
    .tick_o (eff_tick)
  );
`else
  assign eff_tick = tick_en;
`endif

  assign term       = (state_q == ST_RUN) && eff_tick && !pause && (rem_q == WIDTH'(1));
  assign load_ready = !abort && ((state_q == ST_IDLE) || term);
  assign accept     = load_valid && load_ready;

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    dur_d    = dur_q;
    reload_d = reload_q;
    done_d   = 1'b0;

    if (abort) begin
      state_d  = ST_IDLE;
      rem_d    = '0;
      reload_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (duration != '0) begin
              dur_d    = duration;
              reload_d = auto_reload;
              rem_d    = duration;
              state_d  = ST_RUN;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (term) begin
            done_d = 1'b1;
            if (accept && (duration != '0)) begin
              dur_d    = duration;
              reload_d = auto_reload;
              rem_d    = duration;
            end else if (!accept && reload_q) begin
              rem_d = dur_q;
            end else begin
              // Plain expiry, or a zero-length note chained onto the terminal tick
              state_d = ST_IDLE;
              rem_d   = '0;
            end
          end else if (pause) begin
            state_d = ST_PAUSED;
          end else if (eff_tick && (rem_q > WIDTH'(1))) begin
            rem_d = rem_q - WIDTH'(1);
          end
        end
        ST_PAUSED: begin
          if (!pause) begin
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = ST_IDLE;
          rem_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rem_q    <= '0;
      dur_q    <= '0;
      reload_q <= RELOAD_DEFAULT;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      dur_q    <= dur_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  assign busy       = (state_q == ST_RUN) || (state_q == ST_PAUSED);
  assign paused     = (state_q == ST_PAUSED);
  assign remaining  = rem_q;
  assign timer_done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_beat_timer_gen.sv
// +-----------------------------------------------------------------+
// | tb_beat_timer_gen : vector table + scoreboard for beat_timer_gen |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
`default_nettype none

module tb_beat_timer_gen;

  localparam int W = 6;

  typedef struct {
    logic         tick;
    logic         lv;
    logic [W-1:0] dur;
    logic         ar;
    logic         p;
    logic         ab;
    logic         rdy;
    logic         busy;
    logic         pau;
    logic [W-1:0] rem;
    logic         done;
  } vec_t;

  typedef struct {
    logic         busy;
    logic         pau;
    logic [W-1:0] rem;
    logic         done;
    int           idx;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         tick_en = 1'b0;
  logic         load_valid = 1'b0;
  logic         load_ready;
  logic [W-1:0] duration = '0;
  logic         auto_reload = 1'b0;
  logic         pause = 1'b0;
  logic         abort = 1'b0;
  logic         busy;
  logic         paused;
  logic [W-1:0] remaining;
  logic         timer_done;
`ifdef BEAT_TIMER_PRESCALE_EN
  logic [3:0]   presc_div = 4'd0;
`endif

  int tests  = 0;
  int errors = 0;

  vec_t vecs[$];
  exp_t sb[$];

  beat_timer_gen #(
    .WIDTH          (W),
    .RELOAD_DEFAULT (1'b0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick_en     (tick_en),
`ifdef BEAT_TIMER_PRESCALE_EN
    .presc_div   (presc_div),
`endif
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .duration    (duration),
    .auto_reload (auto_reload),
    .pause       (pause),
    .abort       (abort),
    .busy        (busy),
    .paused      (paused),
    .remaining   (remaining),
    .timer_done  (timer_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input int act, input int exp);
    tests++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s (row %0d): got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic add(input int t, input int lv, input int d, input int ar, input int p, input int ab,
                     input int rdy, input int b, input int pa, input int rem, input int dn);
    vec_t v;
    v.tick = 1'(t);  v.lv = 1'(lv); v.dur = W'(d); v.ar = 1'(ar);
    v.p    = 1'(p);  v.ab = 1'(ab); v.rdy = 1'(rdy);
    v.busy = 1'(b);  v.pau = 1'(pa); v.rem = W'(rem); v.done = 1'(dn);
    vecs.push_back(v);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk("busy",       e.idx, int'(busy),       int'(e.busy));
    chk("paused",     e.idx, int'(paused),     int'(e.pau));
    chk("remaining",  e.idx, int'(remaining),  int'(e.rem));
    chk("timer_done", e.idx, int'(timer_done), int'(e.done));
  endtask

  task automatic idle_inputs();
    tick_en = 1'b0; load_valid = 1'b0; duration = '0;
    auto_reload = 1'b0; pause = 1'b0; abort = 1'b0;
  endtask

  initial begin
    //  tick lv dur ar p ab | rdy busy pau rem done
    // basic count, tick every 2nd cycle
    add(0,1,5,0,0,0, 1,1,0,5,0);
    add(1,0,0,0,0,0, 0,1,0,4,0);
    add(0,0,0,0,0,0, 0,1,0,4,0);
    add(1,0,0,0,0,0, 0,1,0,3,0);
    add(0,0,0,0,0,0, 0,1,0,3,0);
    add(1,0,0,0,0,0, 0,1,0,2,0);
    add(0,0,0,0,0,0, 0,1,0,2,0);
    add(1,0,0,0,0,0, 0,1,0,1,0);
    add(0,0,0,0,0,0, 0,1,0,1,0);
    add(1,0,0,0,0,0, 1,0,0,0,1);
    add(0,0,0,0,0,0, 1,0,0,0,0);
    // auto-reload, then abort at remaining 3 with a competing load
    add(0,1,3,1,0,0, 1,1,0,3,0);
    add(1,0,0,0,0,0, 0,1,0,2,0);
    add(1,0,0,0,0,0, 0,1,0,1,0);
    add(1,0,0,0,0,0, 1,1,0,3,1);
    add(1,0,0,0,0,0, 0,1,0,2,0);
    add(1,0,0,0,0,0, 0,1,0,1,0);
    add(1,0,0,0,0,0, 1,1,0,3,1);
    add(1,1,7,0,0,1, 0,0,0,0,0);
    add(0,0,0,0,0,0, 1,0,0,0,0);
    // back-to-back load on the terminal tick
    add(0,1,4,0,0,0, 1,1,0,4,0);
    add(1,0,0,0,0,0, 0,1,0,3,0);
    add(1,0,0,0,0,0, 0,1,0,2,0);
    add(1,0,0,0,0,0, 0,1,0,1,0);
    add(1,1,2,0,0,0, 1,1,0,2,1);
    add(1,0,0,0,0,0, 0,1,0,1,0);
    add(1,0,0,0,0,0, 1,0,0,0,1);
    add(0,0,0,0,0,0, 1,0,0,0,0);
    // pause with ticks dropped, resume, abort, pause ignored in IDLE
    add(0,1,6,0,0,0, 1,1,0,6,0);
    add(1,0,0,0,0,0, 0,1,0,5,0);
    add(1,0,0,0,0,0, 0,1,0,4,0);
    add(1,0,0,0,1,0, 0,1,1,4,0);
    add(1,0,0,0,1,0, 0,1,1,4,0);
    add(1,0,0,0,1,0, 0,1,1,4,0);
    add(1,0,0,0,1,0, 0,1,1,4,0);
    add(1,0,0,0,1,0, 0,1,1,4,0);
    add(0,0,0,0,0,0, 0,1,0,4,0);
    add(1,0,0,0,0,0, 0,1,0,3,0);
    add(0,0,0,0,0,1, 0,0,0,0,0);
    add(1,0,0,0,1,0, 1,0,0,0,0);
    // zero-length load
    add(0,1,0,0,0,0, 1,0,0,0,1);
    add(0,0,0,0,0,0, 1,0,0,0,0);

    idle_inputs();
    repeat (3) @(negedge clk);
    chk("rst_busy",  -1, int'(busy),       0);
    chk("rst_rem",   -1, int'(remaining),  0);
    chk("rst_done",  -1, int'(timer_done), 0);
    chk("rst_ready", -1, int'(load_ready), 1);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      exp_t e;
      @(negedge clk);
      pop_check();
      tick_en     = vecs[i].tick;
      load_valid  = vecs[i].lv;
      duration    = vecs[i].dur;
      auto_reload = vecs[i].ar;
      pause       = vecs[i].p;
      abort       = vecs[i].ab;
      #1;
      chk("load_ready", i, int'(load_ready), int'(vecs[i].rdy));
      e.busy = vecs[i].busy; e.pau = vecs[i].pau; e.rem = vecs[i].rem;
      e.done = vecs[i].done; e.idx = i;
      sb.push_back(e);
    end
    @(negedge clk);
    pop_check();
    idle_inputs();

    // asynchronous reset in the middle of a count
    @(negedge clk);
    load_valid = 1'b1; duration = W'(9);
    @(negedge clk);
    load_valid = 1'b0; tick_en = 1'b1;
    @(negedge clk);
    tick_en = 1'b0;
    chk("pre_rst_rem", 100, int'(remaining), 8);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 101, int'(busy),      0);
    chk("arst_rem",  101, int'(remaining), 0);
    chk("arst_done", 101, int'(timer_done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 102, int'(busy), 0);

`ifdef BEAT_TIMER_PRESCALE_EN
    // divide-by-3: remaining steps once per three tick_en pulses
    presc_div = 4'd2;
    load_valid = 1'b1; duration = W'(4);
    @(negedge clk);
    load_valid = 1'b0; tick_en = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("presc_rem", 200 + k, int'(remaining), 4 - (k / 3));
    end
    idle_inputs();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation ran past its time budget");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/beat_timer_gen.md
Name: beat_timer_gen

Overview:
- Parametrised successor to the music player's per-note beat timer.
- Accepts a note duration through a valid/ready handshake, then counts down on a beat tick enable.
- Supports pause/resume, abort, one-shot or auto-reload modes, and a seamless back-to-back load on the terminal tick.
- Sits between the note sequencer (duration source) and the beat tick generator; its done pulse advances the sequencer to the next note.

Parameters:
- WIDTH, 6, width of duration, remaining count and internal counters; maximum duration is 2^WIDTH-1 ticks.
- RELOAD_DEFAULT, 0, value of the auto-reload latch after reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- tick_en  input  1  one-cycle beat tick; counting advances only on ticks.
- load_valid  input  1  sequencer presents a new duration.
- load_ready  output  1  timer accepts a load this cycle.
- duration  input  WIDTH  note length in ticks; sampled when load_valid && load_ready.
- auto_reload  input  1  mode sampled with the load; 1 = repeat the same duration indefinitely.
- pause  input  1  level; freezes counting while high.
- abort  input  1  synchronous cancel.
- busy  output  1  high in RUN or PAUSED.
- paused  output  1  high in PAUSED.
- remaining  output  WIDTH  ticks left in the current period.
- timer_done  output  1  registered one-cycle pulse after a period completes.

Behaviour:
- Reset (rst_n low, asynchronous) forces:
  - state IDLE;
  - remaining 0, duration latch 0, timer_done 0;
  - auto-reload latch = RELOAD_DEFAULT;
  - prescaler count 0.
- States:
  - IDLE: nothing loaded.
  - RUN: counting.
  - PAUSED: counting frozen.
  - busy and paused are decoded combinationally from state.
- Accept: load_valid && load_ready.
- Terminal tick (term): state==RUN && eff_tick && !pause && remaining==1.
  - eff_tick = tick_en, or the prescaler output when the optional feature is compiled in.
- load_ready = !abort && (state==IDLE || term).
- Load acceptance with duration != 0:
  - latch duration and auto_reload;
  - remaining <= duration; state <= RUN.
- Load acceptance with duration==0:
  - no state change; remaining stays 0;
  - timer_done pulses the next cycle.
- RUN, eff_tick && !pause && remaining>1: remaining decrements by 1.
- On term, timer_done <= 1 for exactly one cycle (visible the cycle after term). Next state, in priority order:
  1. abort: IDLE.
  2. accepted load: new duration, RUN.
  3. auto-reload latch set: remaining <= latched duration, RUN.
  4. otherwise: IDLE, remaining <= 0.
- Pause:
  - RUN && pause -> PAUSED; PAUSED && !pause -> RUN.
  - Ticks arriving while pause is high are dropped, not queued, including the cycle pause first rises.
- Abort, in any state: next state IDLE, remaining 0, no timer_done, auto-reload latch cleared.
  - abort overrides a simultaneous load (load_ready forced low) and a simultaneous term.
- Arithmetic:
  - remaining never wraps below 0 and is never loaded above the duration.
  - WIDTH-bit unsigned throughout.
- In IDLE, tick_en and pause are ignored.

Optional Feature:
- Macro: BEAT_TIMER_PRESCALE_EN.
- When defined:
  - adds parameter PRESC_W (default 4) and input presc_div [PRESC_W-1:0];
  - eff_tick asserts on every (presc_div+1)-th tick_en;
  - prescaler count is cleared on reset, load acceptance, abort and reload;
  - prescaler count holds while paused;
  - presc_div is sampled live.
- When undefined: eff_tick = tick_en, and neither the port nor the parameter exists.

Decomposition:
- Shared package beat_timer_pkg holds:
  - state encoding: IDLE=2'd0, RUN=2'd1, PAUSED=2'd2;
  - default WIDTH and PRESC_W constants.
- One sub-module, beat_prescaler: tick divider with clear/hold inputs, instantiated only under BEAT_TIMER_PRESCALE_EN.

Test Plan:
- Basic count:
  - Stimulus: reset, then load duration=5, auto_reload=0, tick_en every 2nd cycle.
  - Response: remaining 5,4,3,2,1; timer_done pulses once the cycle after the 5th tick; then IDLE with remaining 0 and busy=0.
- Auto-reload:
  - Stimulus: duration=3, auto_reload=1, tick_en every cycle for 10 cycles.
  - Response: timer_done pulses 3 cycles apart (3 pulses); remaining sequence 3,2,1,3,2,1,...
- Back-to-back load:
  - Stimulus: duration=4 loaded; on its term cycle present load_valid with duration=2.
  - Response: load_ready=1 that cycle; timer_done pulses; remaining becomes 2 with no IDLE gap.
- Pause:
  - Stimulus: duration=6; after 2 ticks hold pause high for 5 cycles with ticks continuing.
  - Response: paused=1; remaining frozen at 4; resumes to 3 on the first tick after release.
- Abort/zero:
  - Abort at remaining=3 with a simultaneous load_valid: response IDLE, no done, load rejected.
  - Load duration=0: response single timer_done pulse, state stays IDLE.
- Reset and prescaler:
  - Stimulus: assert rst_n low mid-count.
  - Response: all outputs clear immediately.
  - With BEAT_TIMER_PRESCALE_EN and presc_div=2: remaining decrements every 3rd tick_en.
